// File: rtl/button_int_source.sv
// rtl/button_int_source.sv - debounced push-button interrupt source with one-hot CPU request handshake
//
// Ports:
//   clk             in   system clock, all state on posedge
//   rst             in   synchronous active-high reset
//   btn_n[3:0]      in   raw active-low buttons, asynchronous to clk; bit 3 has highest priority
//   cpu_int_state   in   high while the CPU is running a button handler
//   buttons_pressed out  registered one-hot (or zero) interrupt request
//   pending[3:0]    out  registered view of latched presses not yet serviced
//
// Build option: BTN_DEBOUNCE_EN
//   defined   - each stable level changes only after DEBOUNCE_CYCLES consecutive differing samples
//   undefined - stable level is the synchronized sample one cycle later; no counters, parameter unused

module button_int_source #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    input  logic       cpu_int_state,
    output logic [3:0] buttons_pressed,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] sample;
    logic [3:0] stable_q;
    logic [3:0] stable_d;
    logic [3:0] prev_q;
    logic [3:0] prev_d;
    logic [3:0] rise;
    logic [1:0] init_q;
    logic       init_active;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic [3:0] pending_q;
    logic [3:0] pending_d;
    logic [3:0] bp_q;
    logic [3:0] bp_d;
    logic [3:0] clr;

    function automatic logic [1:0] prio_idx(input logic [3:0] p);
        if (p[3])      return 2'd3;
        else if (p[2]) return 2'd2;
        else if (p[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'(4'b0001 << idx);
    endfunction

    // The synchronizers reset to 0, which reads as "pressed" after inversion.
    // For the first three edges after reset (until the synchronizer holds real
    // button data) the stable and previous levels are loaded directly from the
    // sample, so a button held through reset is taken as the starting level and
    // produces no press until it is released and pressed again.
    assign sample      = ~sync2_q;
    assign init_active = (init_q != 2'd3);

`ifdef BTN_DEBOUNCE_EN
    logic [19:0] cnt_q [4];
    logic [19:0] cnt_d [4];

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = 20'd0;
            if (init_active) begin
                stable_d[i] = sample[i];
            end else if (sample[i] != stable_q[i]) begin
                if (cnt_q[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    stable_d[i] = sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) cnt_q[i] <= 20'd0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^DEBOUNCE_CYCLES;

    always_comb begin
        stable_d = sample;
    end
`endif

    assign prev_d = init_active ? stable_d : stable_q;
    assign rise   = stable_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        clr     = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if ((pending_q != 4'b0000) && !cpu_int_state) begin
                    sel_d   = prio_idx(pending_q);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (cpu_int_state) begin
                    clr     = onehot(sel_q);
                    state_d = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (!cpu_int_state) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new rise on the bit being acknowledged wins over the clear.
        pending_d = (pending_q & ~clr) | rise;
        bp_d      = (state_d == S_REQ) ? onehot(sel_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            stable_q  <= 4'b0000;
            prev_q    <= 4'b0000;
            init_q    <= 2'd0;
            state_q   <= S_IDLE;
            sel_q     <= 2'd0;
            pending_q <= 4'b0000;
            bp_q      <= 4'b0000;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            prev_q    <= prev_d;
            if (init_active) init_q <= init_q + 2'd1;
            state_q   <= state_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
            bp_q      <= bp_d;
        end
    end

    assign buttons_pressed = bp_q;
    assign pending         = pending_q;

endmodule
